// File: rtl/fp32_pkg.sv
// Shared fp32 constants and the converter state encoding.
// Also consumed by the fp32 compare/threshold logic.
package fp32_pkg;

    localparam int unsigned FP32_BIAS  = 127;
    localparam int unsigned FP32_EXP_W = 8;
    localparam int unsigned FP32_MAN_W = 23;

    localparam logic [31:0] FP32_ZERO = 32'h0000_0000;
    localparam logic [31:0] FP32_HALF = 32'h3F00_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_DONE = 2'd2
    } fp32_conv_state_e;

endpackage

// File: rtl/int_to_fp32.sv
// Integer to IEEE-754 single converter; iterative normalisation, one left shift per clock.
// Inputs of at most 24 bits fit the 24-bit significand, so every result is exact.
module int_to_fp32
    import fp32_pkg::*;
#(
    parameter int unsigned IN_W   = 16,
    parameter bit          SIGNED = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [IN_W-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [31:0]     out_data,
    output logic            busy
);

    localparam int unsigned PAD_W = 24 - IN_W;
    localparam logic [FP32_EXP_W-1:0] EXP_INIT = FP32_EXP_W'(FP32_BIAS + IN_W - 1);

    fp32_conv_state_e r_state, w_state_nxt;

    logic                  r_sign,  w_sign_nxt;
    logic [IN_W-1:0]       r_mag,   w_mag_nxt;
    logic [FP32_EXP_W-1:0] r_exp,   w_exp_nxt;
    logic [31:0]           r_out,   w_out_nxt;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;

    logic                  w_sign_in;
    logic [IN_W-1:0]       w_mag_in;
    logic [FP32_MAN_W-1:0] w_man;

    // Magnitude of the incoming word; the most negative value maps onto 2^(IN_W-1).
    assign w_sign_in = SIGNED & in_data[IN_W-1];
    assign w_mag_in  = w_sign_in ? ((~in_data) + IN_W'(1)) : in_data;

    // Drop the hidden bit and left-align the fraction into 23 bits.
    assign w_man = FP32_MAN_W'(24'(r_mag) << PAD_W);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        w_state_nxt = r_state;
        w_sign_nxt  = r_sign;
        w_mag_nxt   = r_mag;
        w_exp_nxt   = r_exp;
        w_out_nxt   = r_out;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    w_sign_nxt = w_sign_in;
                    w_mag_nxt  = w_mag_in;
                    w_exp_nxt  = EXP_INIT;
                    if (w_mag_in == '0) begin
                        w_out_nxt   = FP32_ZERO;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                if (r_mag[IN_W-1]) begin
                    w_out_nxt   = {r_sign, r_exp, w_man};
                    w_state_nxt = ST_DONE;
                end else begin
                    w_mag_nxt = r_mag << 1;
                    w_exp_nxt = r_exp - FP32_EXP_W'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Datapath and registered status flags, decoded from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sign      <= 1'b0;
            r_mag       <= '0;
            r_exp       <= '0;
            r_out       <= FP32_ZERO;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_sign      <= w_sign_nxt;
            r_mag       <= w_mag_nxt;
            r_exp       <= w_exp_nxt;
            r_out       <= w_out_nxt;
            r_in_ready  <= (w_state_nxt == ST_IDLE);
            r_out_valid <= (w_state_nxt == ST_DONE);
            r_busy      <= (w_state_nxt == ST_NORM);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign out_data  = r_out;

endmodule

// File: tb/tb_int_to_fp32.sv
// Self-checking bench for int_to_fp32: directed vectors, handshake/reset corners,
// and a randomized sweep over several widths against an arithmetic reference model.
module tb_int_to_fp32;

    logic clk;
    logic rst_n;
    logic rst_n_dir;

    int n_cmp  = 0;
    int n_fail = 0;
    int n_sweep_done = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", nm, act, req);
        end
    endtask

    // Reference: value = (-1)^s * mag, mag = 2^e * 1.f ; latency = leading zeros + 1.
    function automatic void ref_conv(input longint unsigned raw, input int w, input bit s,
                                     output logic [31:0] f, output int lat);
        longint unsigned mag;
        bit neg;
        int e;
        neg = s && raw[w-1];
        mag = neg ? ((64'd1 << w) - raw) : raw;
        if (mag == 0) begin
            f   = 32'h0;
            lat = 0;
        end else begin
            e = 0;
            while ((mag >> (e + 1)) != 0) e++;
            f   = {neg, 8'(127 + e), 23'((mag - (64'd1 << e)) << (23 - e))};
            lat = (w - 1 - e) + 1;
        end
    endfunction

    // Directed DUT: IN_W=16, SIGNED=1, with its own reset
    logic        d_iv, d_ir, d_ov, d_ordy, d_bz;
    logic [15:0] d_id;
    logic [31:0] d_od;

    int_to_fp32 #(.IN_W(16), .SIGNED(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n_dir),
        .in_valid(d_iv), .in_ready(d_ir), .in_data(d_id),
        .out_valid(d_ov), .out_ready(d_ordy), .out_data(d_od), .busy(d_bz)
    );

    // Unsigned DUT: IN_W=16, SIGNED=0
    logic        u_iv, u_ir, u_ov, u_ordy, u_bz;
    logic [15:0] u_id;
    logic [31:0] u_od;

    int_to_fp32 #(.IN_W(16), .SIGNED(1'b0)) u_uns (
        .clk(clk), .rst_n(rst_n),
        .in_valid(u_iv), .in_ready(u_ir), .in_data(u_id),
        .out_valid(u_ov), .out_ready(u_ordy), .out_data(u_od), .busy(u_bz)
    );

    task automatic conv16(input logic [15:0] din, output logic [31:0] res,
                          output int lat, output int nbusy);
        @(negedge clk);
        d_id = din;
        d_iv = 1'b1;
        @(posedge clk);
        #1;
        d_iv  = 1'b0;
        lat   = 0;
        nbusy = 0;
        while (!d_ov && lat < 40) begin
            if (d_bz) nbusy++;
            @(posedge clk);
            #1;
            lat++;
        end
        res = d_od;
    endtask

    task automatic handoff16();
        @(negedge clk);
        d_ordy = 1'b1;
        @(posedge clk);
        #1;
        d_ordy = 1'b0;
    endtask

    // Randomized sweep instances
    for (genvar g = 0; g < 5; g++) begin : g_sw
        localparam int unsigned W = (g == 0) ? 2 : (g == 1) ? 8 : (g == 2) ? 24 : 16;
        localparam bit S = (g != 4);

        logic         iv, ir, ov, ordy, bz;
        logic [W-1:0] id;
        logic [31:0]  od;

        int_to_fp32 #(.IN_W(W), .SIGNED(S)) u_rnd (
            .clk(clk), .rst_n(rst_n),
            .in_valid(iv), .in_ready(ir), .in_data(id),
            .out_valid(ov), .out_ready(ordy), .out_data(od), .busy(bz)
        );

        initial begin
            logic [31:0] ef;
            int el;
            int cyc;
            iv   = 1'b0;
            ordy = 1'b0;
            id   = '0;
            wait (rst_n === 1'b1);
            for (int n = 0; n < 400; n++) begin
                if ($urandom_range(15) == 0)      id = '0;
                else if ($urandom_range(1) == 1)  id = W'($urandom);
                else                              id = W'($urandom >> $urandom_range(31, 0));
                ref_conv(longint'(id), W, S, ef, el);
                @(negedge clk);
                check($sformatf("sweep_w%0d_ready", W), 32'(ir), 32'd1);
                iv = 1'b1;
                @(posedge clk);
                #1;
                iv  = 1'b0;
                cyc = 0;
                while (!ov && cyc < int'(W) + 4) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                check($sformatf("sweep_w%0d_s%0d_data(in=%h)", W, S, id), od, ef);
                check($sformatf("sweep_w%0d_s%0d_lat(in=%h)", W, S, id), 32'(cyc), 32'(el));
                @(negedge clk);
                ordy = 1'b1;
                @(posedge clk);
                #1;
                ordy = 1'b0;
            end
            n_sweep_done++;
        end
    end

    typedef struct {
        logic [15:0] din;
        logic [31:0] res;
        int          lat;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [31:0] res;
        int lat;
        int nbusy;
        int waited;

        tbl[0] = '{16'h0001, 32'h3F80_0000, 16};
        tbl[1] = '{16'h0000, 32'h0000_0000, 0};
        tbl[2] = '{16'h8000, 32'hC700_0000, 1};
        tbl[3] = '{16'h7FFF, 32'h46FF_FE00, 2};
        tbl[4] = '{16'hFFFE, 32'hC000_0000, 15};
        tbl[5] = '{16'h0003, 32'h4040_0000, 15};
        tbl[6] = '{16'hFF00, 32'hC380_0000, 8};

        rst_n = 1'b0; rst_n_dir = 1'b0;
        d_iv = 1'b0; d_ordy = 1'b0; d_id = '0;
        u_iv = 1'b0; u_ordy = 1'b0; u_id = '0;
        #12;
        check("reset_in_ready", 32'(d_ir), 32'd1);
        check("reset_out_valid", 32'(d_ov), 32'd0);
        check("reset_busy", 32'(d_bz), 32'd0);
        check("reset_out_data", d_od, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; rst_n_dir = 1'b1;

        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), 32'(d_ir), 32'd1);
            conv16(tbl[i].din, res, lat, nbusy);
            check($sformatf("vec%0d_data", i), res, tbl[i].res);
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'(tbl[i].lat));
            check($sformatf("vec%0d_busy_cycles", i), 32'(nbusy), 32'(tbl[i].lat));
            handoff16();
            check($sformatf("vec%0d_ready_after", i), 32'(d_ir), 32'd1);
        end

        // Unsigned full-scale input
        @(negedge clk);
        u_id = 16'hFFFF;
        u_iv = 1'b1;
        @(posedge clk);
        #1;
        u_iv = 1'b0;
        lat = 0;
        while (!u_ov && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("uns_ffff_data", u_od, 32'h477F_FF00);
        check("uns_ffff_lat", 32'(lat), 32'd1);
        @(negedge clk);
        u_ordy = 1'b1;
        @(posedge clk);
        #1;
        u_ordy = 1'b0;

        // Backpressure: result held, no new acceptance while out_ready is low
        conv16(16'd3, res, lat, nbusy);
        check("bp_first", res, 32'h4040_0000);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            d_id   = 16'd5;
            d_iv   = 1'b1;
            d_ordy = 1'b0;
            @(posedge clk);
            #1;
            check($sformatf("bp_hold_data%0d", k), d_od, 32'h4040_0000);
            check($sformatf("bp_hold_ready%0d", k), 32'(d_ir), 32'd0);
            check($sformatf("bp_hold_valid%0d", k), 32'(d_ov), 32'd1);
        end
        @(negedge clk);
        d_iv   = 1'b0;
        d_ordy = 1'b1;
        @(posedge clk);
        #1;
        d_ordy = 1'b0;
        check("bp_release_ready", 32'(d_ir), 32'd1);
        check("bp_release_valid", 32'(d_ov), 32'd0);
        check("bp_release_busy", 32'(d_bz), 32'd0);

        // Asynchronous reset in the middle of a conversion
        @(negedge clk);
        d_id = 16'd1;
        d_iv = 1'b1;
        @(posedge clk);
        #1;
        d_iv = 1'b0;
        repeat (5) @(posedge clk);
        #2;
        check("mid_busy_before_rst", 32'(d_bz), 32'd1);
        rst_n_dir = 1'b0;
        #1;
        check("rst_mid_valid", 32'(d_ov), 32'd0);
        check("rst_mid_busy", 32'(d_bz), 32'd0);
        check("rst_mid_ready", 32'(d_ir), 32'd1);
        check("rst_mid_data", d_od, 32'h0);
        @(negedge clk);
        rst_n_dir = 1'b1;
        conv16(16'd2, res, lat, nbusy);
        check("post_rst_data", res, 32'h4000_0000);
        check("post_rst_lat", 32'(lat), 32'd15);
        handoff16();

        waited = 0;
        while (n_sweep_done < 5 && waited < 60000) begin
            @(posedge clk);
            waited++;
        end
        check("sweep_complete", 32'(n_sweep_done), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
